// File: rtl/gcd_result_tx.sv
// gcd_result_tx: captures each GCD result and streams it as ASCII decimal
// bytes (optionally CR LF terminated) over a valid/ready byte handshake.
module gcd_result_tx #(
  parameter int unsigned NEWLINE_EN    = 1,
  parameter int unsigned ZERO_SUPPRESS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] gcd_in,
  input  logic        finished_in,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done,
  output logic        dropped
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONVERT,
    S_SEND,
    S_TRAIL,
    S_FINISH
  } state_t;

  state_t      state;
  logic        fin_q;
  logic [15:0] bin_r;
  logic [19:0] bcd_r;
  logic [3:0]  cnt;
  logic [2:0]  idx;

  logic        start;
  logic [19:0] adj;
  logic [19:0] next_bcd;
  logic [2:0]  idx_m1;
  logic [3:0]  cur_digit;
  logic [3:0]  nxt_digit;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [3:0] pick(
    input logic [19:0] b,
    input logic [2:0]  i
  );
    case (i)
      3'd4:    return b[19:16];
      3'd3:    return b[15:12];
      3'd2:    return b[11:8];
      3'd1:    return b[7:4];
      default: return b[3:0];
    endcase
  endfunction

  function automatic logic [7:0] ascii(input logic [3:0] d);
    return {4'h3, d};
  endfunction

  assign start = finished_in & ~fin_q;
  assign idx_m1 = idx - 3'd1;
  assign cur_digit = pick(bcd_r, idx);
  assign nxt_digit = pick(bcd_r, idx_m1);

  always_comb begin
    adj = '0;
    for (int i = 0; i < 5; i++) begin
      adj[4*i +: 4] = add3(bcd_r[4*i +: 4]);
    end
  end

  assign next_bcd = {adj[18:0], bin_r[15]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      fin_q    <= 1'b0;
      bin_r    <= '0;
      bcd_r    <= '0;
      cnt      <= '0;
      idx      <= '0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dropped  <= 1'b0;
    end else begin
      fin_q <= finished_in;
      done  <= 1'b0;

      if (start && (state == S_CONVERT ||
                    state == S_SEND ||
                    state == S_TRAIL)) begin
        dropped <= 1'b1;
      end

      unique case (state)
        S_IDLE, S_FINISH: begin
          if (start) begin
            bin_r <= gcd_in;
            bcd_r <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_CONVERT;
          end else begin
            state <= S_IDLE;
          end
        end

        S_CONVERT: begin
          bcd_r <= next_bcd;
          bin_r <= {bin_r[14:0], 1'b0};
          cnt   <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            state <= S_SEND;
            // d4 is resolved on the last shift so an unsuppressed
            // message presents its first byte with no extra cycle
            if (ZERO_SUPPRESS == 0 || next_bcd[19:16] != 4'd0) begin
              idx      <= 3'd4;
              tx_data  <= ascii(next_bcd[19:16]);
              tx_valid <= 1'b1;
            end else begin
              idx <= 3'd3;
            end
          end
        end

        S_SEND: begin
          if (tx_valid) begin
            if (tx_ready) begin
              if (idx == 3'd0) begin
                if (NEWLINE_EN != 0) begin
                  state   <= S_TRAIL;
                  tx_data <= 8'h0D;
                end else begin
                  state    <= S_FINISH;
                  tx_valid <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                end
              end else begin
                idx     <= idx_m1;
                tx_data <= ascii(nxt_digit);
              end
            end
          end else if (ZERO_SUPPRESS != 0 && idx != 3'd0 &&
                       cur_digit == 4'd0) begin
            idx <= idx_m1;
          end else begin
            tx_data  <= ascii(cur_digit);
            tx_valid <= 1'b1;
          end
        end

        S_TRAIL: begin
          if (tx_ready) begin
            if (tx_data == 8'h0D) begin
              tx_data <= 8'h0A;
            end else begin
              state    <= S_FINISH;
              tx_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_result_tx.sv
// tb_gcd_result_tx: scoreboard bench for gcd_result_tx across three
// parameter sets (default, no zero suppression, no newline).
module tb_gcd_result_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] gcd_in;
  logic [2:0]  fin;
  logic        tx_ready;
  logic [7:0]  tx_data [3];
  logic        tx_valid [3];
  logic        busy [3];
  logic        done [3];
  logic        dropped [3];

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];
  int done_cnt;
  int stall_err;
  int first_valid;
  int xfer_first;
  int xfer_last;
  bit timed_out;
  bit busy_seen;

  always #5 clk = ~clk;

  gcd_result_tx #(.NEWLINE_EN(1), .ZERO_SUPPRESS(1)) dut_a (
    .clk(clk), .rst(rst), .gcd_in(gcd_in), .finished_in(fin[0]),
    .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready),
    .busy(busy[0]), .done(done[0]), .dropped(dropped[0])
  );

  gcd_result_tx #(.NEWLINE_EN(1), .ZERO_SUPPRESS(0)) dut_b (
    .clk(clk), .rst(rst), .gcd_in(gcd_in), .finished_in(fin[1]),
    .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready),
    .busy(busy[1]), .done(done[1]), .dropped(dropped[1])
  );

  gcd_result_tx #(.NEWLINE_EN(0), .ZERO_SUPPRESS(1)) dut_c (
    .clk(clk), .rst(rst), .gcd_in(gcd_in), .finished_in(fin[2]),
    .tx_data(tx_data[2]), .tx_valid(tx_valid[2]), .tx_ready(tx_ready),
    .busy(busy[2]), .done(done[2]), .dropped(dropped[2])
  );

  // Expected bytes come from the simulator's own decimal formatting.
  task automatic push_expected(input int val, input bit zs, input bit nl);
    string s;
    s = zs ? $sformatf("%0d", val) : $sformatf("%05d", val);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
    if (nl) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  task automatic kick(input int sel, input logic [15:0] val);
    @(negedge clk);
    tx_ready = 1'b1;
    gcd_in = val;
    fin[sel] = 1'b1;
    @(negedge clk);
    fin[sel] = 1'b0;
  endtask

  // mode 0: ready always high; mode 1: ready high one cycle in four.
  // inj >= 0: raise a second edge at that cycle; inj == -2: raise it
  // in the cycle done is seen.
  task automatic collect(input int sel, input int mode,
                         input int inj, input logic [15:0] inj_val);
    bit pv, pr, stop, injected;
    logic [7:0] pd;
    int after, inj_at;
    got_q.delete();
    done_cnt = 0; stall_err = 0; first_valid = -1;
    xfer_first = -1; xfer_last = -1;
    timed_out = 1'b1; busy_seen = 1'b0;
    pv = 1'b0; pr = 1'b0; pd = 8'h00; stop = 1'b0;
    injected = 1'b0; after = -1; inj_at = -10;
    for (int cyc = 2; cyc < 600 && !stop; cyc++) begin
      @(negedge clk);
      if (!injected && ((inj >= 0 && cyc == inj) ||
                        (inj == -2 && done[sel]))) begin
        gcd_in = inj_val;
        fin[sel] = 1'b1;
        injected = 1'b1;
        inj_at = cyc;
      end else if (cyc == inj_at + 1) begin
        fin[sel] = 1'b0;
      end
      tx_ready = (mode == 0) ? 1'b1 : (cyc % 4 == 0);
      if (pv && !pr && (!tx_valid[sel] || tx_data[sel] !== pd))
        stall_err++;
      if (tx_valid[sel] && first_valid < 0) first_valid = cyc;
      if (busy[sel]) busy_seen = 1'b1;
      if (done[sel]) done_cnt++;
      if (tx_valid[sel] && tx_ready) begin
        got_q.push_back(tx_data[sel]);
        if (xfer_first < 0) xfer_first = cyc;
        xfer_last = cyc;
      end
      pv = tx_valid[sel]; pr = tx_ready; pd = tx_data[sel];
      if (done_cnt > 0 && after < 0) after = cyc;
      if (after >= 0 && cyc >= after + 3) begin
        stop = 1'b1;
        timed_out = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; fin = '0; tx_ready = 1'b0; gcd_in = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (tx_valid[0] !== 1'b0) begin
      errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid[0]);
    end
    checks++;
    if (tx_data[0] !== 8'h00) begin
      errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data[0]);
    end
    checks++;
    if (busy[0] !== 1'b0 || done[0] !== 1'b0 || dropped[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got busy=%b done=%b dropped=%b want 000",
               busy[0], done[0], dropped[0]);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0 || tx_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b valid=%b want 00",
               busy[0], tx_valid[0]);
    end
  endtask

  task automatic test_basic;
    logic [7:0] e;
    exp_q.delete();
    push_expected(12, 1, 1);
    kick(0, 16'd12);
    collect(0, 0, -1, 16'd0);
    checks++;
    if (timed_out) begin errors++; $display("FAIL basic_timeout: got none want done"); end
    checks++;
    if (got_q.size() != 4) begin
      errors++; $display("FAIL basic_count: got %0d want 4", got_q.size());
    end
    foreach (got_q[i]) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if (got_q[i] !== e) begin
        errors++; $display("FAIL basic_byte%0d: got %h want %h", i, got_q[i], e);
      end
    end
    checks++;
    if (done_cnt != 1) begin
      errors++; $display("FAIL basic_done: got %0d pulses want 1", done_cnt);
    end
    checks++;
    if (busy[0] !== 1'b0 || !busy_seen) begin
      errors++;
      $display("FAIL basic_busy: got end=%b seen=%b want 0/1", busy[0], busy_seen);
    end
  endtask

  task automatic test_max_back_to_back;
    logic [7:0] e;
    exp_q.delete();
    push_expected(65535, 1, 1);
    kick(0, 16'hFFFF);
    collect(0, 0, -1, 16'd0);
    checks++;
    if (timed_out || got_q.size() != 7) begin
      errors++; $display("FAIL max_count: got %0d want 7", got_q.size());
    end
    foreach (got_q[i]) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if (got_q[i] !== e) begin
        errors++; $display("FAIL max_byte%0d: got %h want %h", i, got_q[i], e);
      end
    end
    checks++;
    if (xfer_last - xfer_first != 6) begin
      errors++;
      $display("FAIL back_to_back_span: got %0d want 6", xfer_last - xfer_first);
    end
    exp_q.delete();
    push_expected(65535, 0, 1);
    kick(1, 16'hFFFF);
    collect(1, 0, -1, 16'd0);
    checks++;
    if (first_valid != 17) begin
      errors++; $display("FAIL latency: got cycle %0d want 17", first_valid);
    end
    checks++;
    if (timed_out || got_q.size() != 7) begin
      errors++; $display("FAIL max_nz_count: got %0d want 7", got_q.size());
    end
    foreach (got_q[i]) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if (got_q[i] !== e) begin
        errors++; $display("FAIL max_nz_byte%0d: got %h want %h", i, got_q[i], e);
      end
    end
  endtask

  task automatic test_zero;
    logic [7:0] e;
    exp_q.delete();
    push_expected(0, 1, 1);
    kick(0, 16'd0);
    collect(0, 0, -1, 16'd0);
    checks++;
    if (timed_out || got_q.size() != 3) begin
      errors++; $display("FAIL zero_count: got %0d want 3", got_q.size());
    end
    foreach (got_q[i]) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if (got_q[i] !== e) begin
        errors++; $display("FAIL zero_byte%0d: got %h want %h", i, got_q[i], e);
      end
    end
    exp_q.delete();
    push_expected(7, 0, 1);
    kick(1, 16'd7);
    collect(1, 0, -1, 16'd0);
    checks++;
    if (timed_out || got_q.size() != 7) begin
      errors++; $display("FAIL pad_count: got %0d want 7", got_q.size());
    end
    foreach (got_q[i]) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if (got_q[i] !== e) begin
        errors++; $display("FAIL pad_byte%0d: got %h want %h", i, got_q[i], e);
      end
    end
  endtask

  task automatic test_no_newline;
    logic [7:0] e;
    exp_q.delete();
    push_expected(805, 1, 0);
    kick(2, 16'd805);
    collect(2, 0, -1, 16'd0);
    checks++;
    if (timed_out || got_q.size() != 3 || done_cnt != 1) begin
      errors++;
      $display("FAIL nonl_count: got %0d bytes %0d done want 3 1",
               got_q.size(), done_cnt);
    end
    foreach (got_q[i]) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if (got_q[i] !== e) begin
        errors++; $display("FAIL nonl_byte%0d: got %h want %h", i, got_q[i], e);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] e;
    exp_q.delete();
    push_expected(345, 1, 1);
    kick(0, 16'd345);
    collect(0, 1, -1, 16'd0);
    checks++;
    if (timed_out || got_q.size() != 5) begin
      errors++; $display("FAIL bp_count: got %0d want 5", got_q.size());
    end
    foreach (got_q[i]) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if (got_q[i] !== e) begin
        errors++; $display("FAIL bp_byte%0d: got %h want %h", i, got_q[i], e);
      end
    end
    checks++;
    if (stall_err != 0) begin
      errors++; $display("FAIL bp_stable: got %0d changes want 0", stall_err);
    end
  endtask

  task automatic test_finish_capture;
    logic [7:0] e;
    exp_q.delete();
    push_expected(3, 1, 1);
    push_expected(4, 1, 1);
    kick(0, 16'd3);
    collect(0, 0, -2, 16'd4);
    checks++;
    if (timed_out || got_q.size() != 3) begin
      errors++; $display("FAIL fincap_first: got %0d want 3", got_q.size());
    end
    foreach (got_q[i]) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if (got_q[i] !== e) begin
        errors++; $display("FAIL fincap_a%0d: got %h want %h", i, got_q[i], e);
      end
    end
    collect(0, 0, -1, 16'd0);
    checks++;
    if (timed_out || got_q.size() != 3) begin
      errors++; $display("FAIL fincap_second: got %0d want 3", got_q.size());
    end
    foreach (got_q[i]) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if (got_q[i] !== e) begin
        errors++; $display("FAIL fincap_b%0d: got %h want %h", i, got_q[i], e);
      end
    end
    checks++;
    if (dropped[0] !== 1'b0) begin
      errors++; $display("FAIL fincap_dropped: got %b want 0", dropped[0]);
    end
  endtask

  task automatic test_overlap;
    logic [7:0] e;
    exp_q.delete();
    push_expected(21, 1, 1);
    kick(0, 16'd21);
    collect(0, 0, 19, 16'd9);
    checks++;
    if (timed_out || got_q.size() != 4) begin
      errors++; $display("FAIL ovl_count: got %0d want 4", got_q.size());
    end
    foreach (got_q[i]) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if (got_q[i] !== e) begin
        errors++; $display("FAIL ovl_byte%0d: got %h want %h", i, got_q[i], e);
      end
    end
    checks++;
    if (dropped[0] !== 1'b1) begin
      errors++; $display("FAIL ovl_dropped: got %b want 1", dropped[0]);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (dropped[0] !== 1'b1 || tx_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL ovl_sticky: got dropped=%b valid=%b busy=%b want 1 0 0",
               dropped[0], tx_valid[0], busy[0]);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] e;
    int n;
    exp_q.delete();
    @(negedge clk);
    tx_ready = 1'b1; gcd_in = 16'd500; fin[0] = 1'b1;
    n = 0;
    for (int c = 0; c < 60 && n == 0; c++) begin
      @(negedge clk);
      if (tx_valid[0] && tx_ready) n++;
    end
    checks++;
    if (n == 0) begin
      errors++; $display("FAIL rstmid_first: got none want one byte");
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (tx_valid[0] !== 1'b0 || busy[0] !== 1'b0 || done[0] !== 1'b0 ||
        dropped[0] !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: got v=%b b=%b d=%b dr=%b want 0000",
               tx_valid[0], busy[0], done[0], dropped[0]);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    push_expected(500, 1, 1);
    collect(0, 0, -1, 16'd0);
    fin[0] = 1'b0;
    checks++;
    if (timed_out || got_q.size() != 5) begin
      errors++; $display("FAIL rstmid_count: got %0d want 5", got_q.size());
    end
    foreach (got_q[i]) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if (got_q[i] !== e) begin
        errors++; $display("FAIL rstmid_byte%0d: got %h want %h", i, got_q[i], e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max_back_to_back();
    test_zero();
    test_no_newline();
    test_backpressure();
    test_finish_capture();
    test_overlap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
